// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end for the pipelined WISC CPU. Owns the fetch PC,
// talks to a variable-latency instruction memory, and presents one registered
// instruction at a time to the decode stage. A one-entry hold buffer catches
// a word that returns while decode is stalled so no fetched word is lost.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous active-high reset
//   stall          decode cannot accept; IF output must hold its value
//   redirect_valid taken branch / misprediction; flush and reload the PC
//   redirect_pc    new fetch address when redirect_valid is high
//   imem_req       instruction memory request
//   imem_addr      request address, stable while imem_req=1 and imem_rdy=0
//   imem_rdy       memory response valid this cycle (may be same cycle as req)
//   imem_data      returned instruction word, valid with imem_rdy
//   if_valid       IF output register holds a valid instruction
//   if_inst        instruction presented to decode
//   if_pc          address of if_inst
//   if_pc_plus2    if_pc + 2, wrapping modulo 2^16
//   hlt_fetched    a HLT has been captured and fetching has stopped
//   pc             current fetch PC
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_inst,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        hlt_fetched,
    output logic [15:0] pc
);

    // S_REQ  : a request for r_pc is on the memory bus
    // S_FULL : the hold buffer has a word waiting for the output to free up
    // S_HALT : a HLT reached the output path; fetching is frozen
    // S_DROP : an old request is still in flight after a redirect and its
    //          data must be thrown away when it finally returns
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_FULL = 2'd1,
        S_HALT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_drop_addr;

    logic        r_if_valid;
    logic [15:0] r_if_inst;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus2;

    logic [15:0] r_hold_inst;
    logic [15:0] r_hold_pc;

    logic        r_hlt_fetched;

    logic        w_consume;
    logic        w_out_free;
    logic        w_req_state;
    logic        w_resp_is_hlt;
    logic        w_hold_is_hlt;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_hold_pc_plus2;
    logic [15:0] w_addr;

    // Handshake with decode: the output is consumed when it is valid and not
    // stalled, and it may be reloaded whenever it is empty or being consumed.
    assign w_consume  = r_if_valid & ~stall;
    assign w_out_free = ~r_if_valid | ~stall;

    // Both S_REQ and S_DROP keep a request on the bus; S_DROP replays the
    // address it had when the redirect arrived so the memory sees a stable
    // request until it answers.
    assign w_req_state = (r_state == S_REQ) || (r_state == S_DROP);
    assign w_addr      = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign w_resp_is_hlt   = (imem_data[15:12] == HLT_OPCODE);
    assign w_hold_is_hlt   = (r_hold_inst[15:12] == HLT_OPCODE);
    assign w_pc_plus2      = r_pc + 16'd2;
    assign w_hold_pc_plus2 = r_hold_pc + 16'd2;

    // The request is decoded from the registered state; rst gates it so the
    // memory never sees a request while the unit is held in reset.
    assign imem_req    = w_req_state & ~rst;
    assign imem_addr   = w_addr;

    assign if_valid    = r_if_valid;
    assign if_inst     = r_if_inst;
    assign if_pc       = r_if_pc;
    assign if_pc_plus2 = r_if_pc_plus2;
    assign hlt_fetched = r_hlt_fetched;
    assign pc          = r_pc;

    // Fetch state machine together with the PC, IF output and hold buffer.
    // A redirect overrides everything else in the cycle: it reloads the PC,
    // flushes the output and hold buffer, clears the halt, and decides
    // whether an in-flight request must be drained in S_DROP. Otherwise each
    // state handles capture and draining, and a consumed output drops valid
    // unless something new is written into it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= PC_RESET;
            r_drop_addr   <= 16'h0000;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 16'h0000;
            r_if_pc       <= 16'h0000;
            r_if_pc_plus2 <= 16'h0000;
            r_hold_inst   <= 16'h0000;
            r_hold_pc     <= 16'h0000;
            r_hlt_fetched <= 1'b0;
        end else begin
            if (w_consume) begin
                r_if_valid <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc          <= redirect_pc;
                r_if_valid    <= 1'b0;
                r_hlt_fetched <= 1'b0;
                r_drop_addr   <= w_addr;
                r_hold_inst   <= 16'h0000;
                r_hold_pc     <= 16'h0000;
                // A response landing in the redirect cycle is simply ignored;
                // only a request still waiting on memory needs draining.
                if (w_req_state && !imem_rdy) begin
                    r_state <= S_DROP;
                end else begin
                    r_state <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (imem_rdy) begin
                            if (w_out_free) begin
                                r_if_valid    <= 1'b1;
                                r_if_inst     <= imem_data;
                                r_if_pc       <= r_pc;
                                r_if_pc_plus2 <= w_pc_plus2;
                            end else begin
                                r_hold_inst <= imem_data;
                                r_hold_pc   <= r_pc;
                            end

                            // A HLT freezes the PC on its own address. If it
                            // went to the hold buffer we still have to wait
                            // in S_FULL before halting.
                            if (w_resp_is_hlt) begin
                                if (w_out_free) begin
                                    r_state       <= S_HALT;
                                    r_hlt_fetched <= 1'b1;
                                end else begin
                                    r_state <= S_FULL;
                                end
                            end else begin
                                r_pc <= w_pc_plus2;
                                if (w_out_free) begin
                                    r_state <= S_REQ;
                                end else begin
                                    r_state <= S_FULL;
                                end
                            end
                        end
                    end

                    S_FULL: begin
                        if (w_consume) begin
                            r_if_valid    <= 1'b1;
                            r_if_inst     <= r_hold_inst;
                            r_if_pc       <= r_hold_pc;
                            r_if_pc_plus2 <= w_hold_pc_plus2;
                            if (w_hold_is_hlt) begin
                                r_state       <= S_HALT;
                                r_hlt_fetched <= 1'b1;
                            end else begin
                                r_state <= S_REQ;
                            end
                        end
                    end

                    S_HALT: begin
                        r_state <= S_HALT;
                    end

                    S_DROP: begin
                        if (imem_rdy) begin
                            r_state <= S_REQ;
                        end
                    end

                    default: begin
                        r_state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory with a
// programmable wait count answers requests. Directed tests push the words
// decode should receive into a scoreboard queue; a monitor pops and compares
// every word the DUT hands to decode. Point checks cover reset values, hold
// buffer, redirects, HLT, PC wrap and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        hlt_fetched;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic [15:0] pc2;
    } exp_t;

    exp_t expQ[$];
    exp_t sbEntry;

    // Memory model: word at address a is mem[a[8:1]]; wait states set by memLat
    logic [15:0] mem [0:255];
    int          memLat = 0;
    int          waitCnt;

    logic        pendPrev = 1'b0;
    logic [15:0] prevAddr = 16'h0000;

    fetch_unit #(
        .PC_RESET   (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pc_plus2    (if_pc_plus2),
        .hlt_fetched    (hlt_fetched),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    // Wait-state counter of the memory model; it answers once the request
    // has been pending for memLat cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= 0;
        end else if (imem_req && !imem_rdy) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    assign imem_rdy  = imem_req && (waitCnt >= memLat);
    assign imem_data = mem[imem_addr[8:1]];

    // Scoreboard monitor: every word decode accepts must match the queue head.
    always @(negedge clk) begin
        if (!rst && if_valid && !stall && !redirect_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got inst=%h pc=%h, required no output", if_inst, if_pc);
            end else begin
                sbEntry = expQ.pop_front();
                if (if_inst !== sbEntry.inst || if_pc !== sbEntry.pc || if_pc_plus2 !== sbEntry.pc2) begin
                    errors++;
                    $display("[TB] FAIL sb_word: got inst=%h pc=%h pc2=%h, required inst=%h pc=%h pc2=%h",
                             if_inst, if_pc, if_pc_plus2, sbEntry.inst, sbEntry.pc, sbEntry.pc2);
                end
            end
        end
    end

    // Protocol monitor: a request not yet answered must stay on the bus unchanged.
    always @(negedge clk) begin
        if (!rst && pendPrev) begin
            checks++;
            if (!imem_req || imem_addr !== prevAddr) begin
                errors++;
                $display("[TB] FAIL req_stable: got req=%b addr=%h, required req=1 addr=%h",
                         imem_req, imem_addr, prevAddr);
            end
        end
        pendPrev = !rst && imem_req && !imem_rdy;
        prevAddr = imem_addr;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic stallV, input logic redirV, input logic [15:0] redirPc);
        rst            = rstV;
        stall          = stallV;
        redirect_valid = redirV;
        redirect_pc    = redirPc;
    endtask

    task automatic expectWord(input logic [15:0] inst, input logic [15:0] wpc, input logic [15:0] wpc2);
        exp_t e;
        e.inst = inst;
        e.pc   = wpc;
        e.pc2  = wpc2;
        expQ.push_back(e);
    endtask

    task automatic holdReset(input int lat, input logic stallV);
        applyStimulus(1'b1, stallV, 1'b0, 16'h0000);
        memLat = lat;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Run until the scoreboard is empty, then stall so nothing else is taken.
    task automatic waitDrain(input int maxCycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                stall = 1'b1;
                done  = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d words outstanding, required 0", expQ.size());
            expQ.delete();
            stall = 1'b1;
        end
    endtask

    task automatic waitAddr(input logic [15:0] addr, input int maxCycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (imem_req && imem_addr == addr) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: got addr=%h req=%b, required addr=%h req=1", name, imem_addr, imem_req, addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h2000 | 16'(i * 2);
        end
        mem[0] = 16'hA1B2;
        mem[1] = 16'hC3D4;
        mem[2] = 16'hE5F6;

        // Test 1: zero-wait memory, reset values, one word per cycle
        $display("[TB] test 1: zero-wait streaming");
        holdReset(0, 1'b0);
        checkOutput("rst_if_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("rst_if_inst", if_inst, 16'h0000);
        checkOutput("rst_if_pc", if_pc, 16'h0000);
        checkOutput("rst_if_pc_plus2", if_pc_plus2, 16'h0000);
        checkOutput("rst_hlt", {15'd0, hlt_fetched}, 16'h0000);
        checkOutput("rst_imem_req", {15'd0, imem_req}, 16'h0000);
        checkOutput("rst_pc", pc, 16'h0000);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        expectWord(16'hE5F6, 16'h0004, 16'h0006);
        releaseReset();
        checkOutput("t1_first_addr", imem_addr, 16'h0000);
        @(posedge clk); #1;
        checkOutput("t1_valid_c1", {15'd0, if_valid}, 16'h0001);
        checkOutput("t1_pc_c1", if_pc, 16'h0000);
        @(posedge clk); #1;
        checkOutput("t1_pc_c2", if_pc, 16'h0002);
        @(posedge clk); #1;
        checkOutput("t1_pc_c3", if_pc, 16'h0004);
        checkOutput("t1_pc2_c3", if_pc_plus2, 16'h0006);
        waitDrain(10);

        // Test 2: 3 wait states, decode stalled so the second word is held
        $display("[TB] test 2: hold buffer under stall");
        holdReset(3, 1'b1);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        releaseReset();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (if_valid) break;
        end
        checkOutput("t2_first_valid", {15'd0, if_valid}, 16'h0001);
        checkOutput("t2_first_inst", if_inst, 16'hA1B2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t2_full_req", {15'd0, imem_req}, 16'h0000);
        checkOutput("t2_full_pc", pc, 16'h0004);
        checkOutput("t2_held_inst", if_inst, 16'hA1B2);
        checkOutput("t2_held_valid", {15'd0, if_valid}, 16'h0001);
        stall = 1'b0;
        waitDrain(20);

        // Test 3: redirect while a slow request to 0x0006 is outstanding
        $display("[TB] test 3: redirect with request in flight");
        holdReset(3, 1'b0);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        expectWord(16'hE5F6, 16'h0004, 16'h0006);
        expectWord(16'h2040, 16'h0040, 16'h0042);
        expectWord(16'h2042, 16'h0042, 16'h0044);
        releaseReset();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (imem_req && imem_addr == 16'h0006 && !imem_rdy && !if_valid) break;
        end
        checkOutput("t3_pending_addr", imem_addr, 16'h0006);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("t3_flush_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("t3_flush_pc", pc, 16'h0040);
        checkOutput("t3_drop_addr", imem_addr, 16'h0006);
        waitAddr(16'h0040, 20, "t3_next_addr");
        waitDrain(40);

        // Test 4a: HLT at 0x0008 stops fetching
        $display("[TB] test 4: HLT handling");
        mem[4] = 16'hF000;
        holdReset(0, 1'b0);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        expectWord(16'hE5F6, 16'h0004, 16'h0006);
        expectWord(16'h2006, 16'h0006, 16'h0008);
        expectWord(16'hF000, 16'h0008, 16'h000A);
        releaseReset();
        waitDrain(20);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("t4_halt_pc", pc, 16'h0008);
            checkOutput("t4_halt_flag", {15'd0, hlt_fetched}, 16'h0001);
            checkOutput("t4_halt_req", {15'd0, imem_req}, 16'h0000);
        end
        checkOutput("t4_halt_drained", {15'd0, if_valid}, 16'h0000);

        // Test 4b: redirect in the HLT capture cycle discards the HLT
        holdReset(0, 1'b0);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        expectWord(16'hE5F6, 16'h0004, 16'h0006);
        expectWord(16'h2010, 16'h0010, 16'h0012);
        expectWord(16'h2012, 16'h0012, 16'h0014);
        releaseReset();
        waitAddr(16'h0008, 20, "t4b_hlt_addr");
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("t4b_hlt_flag", {15'd0, hlt_fetched}, 16'h0000);
        checkOutput("t4b_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("t4b_pc", pc, 16'h0010);
        checkOutput("t4b_addr", imem_addr, 16'h0010);
        waitDrain(20);
        mem[4] = 16'h2008;

        // Test 5: redirect together with stall on a valid output
        $display("[TB] test 5: redirect beats stall");
        holdReset(0, 1'b1);
        releaseReset();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5_pre_valid", {15'd0, if_valid}, 16'h0001);
        checkOutput("t5_pre_inst", if_inst, 16'hA1B2);
        checkOutput("t5_pre_req", {15'd0, imem_req}, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020);
        @(posedge clk); #1;
        checkOutput("t5_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("t5_pc", pc, 16'h0020);
        checkOutput("t5_addr", imem_addr, 16'h0020);
        expectWord(16'h2020, 16'h0020, 16'h0022);
        expectWord(16'h2022, 16'h0022, 16'h0024);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        waitDrain(20);

        // Test 6a: async reset while draining a dropped request
        $display("[TB] test 6: asynchronous reset");
        holdReset(3, 1'b1);
        releaseReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0030);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("t6a_drop_pc", pc, 16'h0030);
        checkOutput("t6a_drop_addr", imem_addr, 16'h0000);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("t6a_rst_req", {15'd0, imem_req}, 16'h0000);
        checkOutput("t6a_rst_pc", pc, 16'h0000);
        releaseReset();
        #1;
        checkOutput("t6a_restart_addr", imem_addr, 16'h0000);
        checkOutput("t6a_restart_req", {15'd0, imem_req}, 16'h0001);

        // Test 6b: async reset while the hold buffer is full
        holdReset(0, 1'b1);
        releaseReset();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6b_full_pc", pc, 16'h0004);
        checkOutput("t6b_full_valid", {15'd0, if_valid}, 16'h0001);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("t6b_rst_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("t6b_rst_inst", if_inst, 16'h0000);
        checkOutput("t6b_rst_pc2", if_pc_plus2, 16'h0000);
        checkOutput("t6b_rst_pc", pc, 16'h0000);
        checkOutput("t6b_rst_req", {15'd0, imem_req}, 16'h0000);
        releaseReset();
        #1;
        checkOutput("t6b_restart_addr", imem_addr, 16'h0000);

        // Test 7: redirect coinciding with a response, then PC wrap at 0xFFFE
        $display("[TB] test 7: redirect on response and PC wrap");
        holdReset(0, 1'b0);
        expectWord(16'h21FE, 16'hFFFE, 16'h0000);
        expectWord(16'hA1B2, 16'h0000, 16'h0002);
        expectWord(16'hC3D4, 16'h0002, 16'h0004);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("t7_valid", {15'd0, if_valid}, 16'h0000);
        checkOutput("t7_pc", pc, 16'hFFFE);
        @(posedge clk); #1;
        checkOutput("t7_wrap_pc", pc, 16'h0000);
        waitDrain(20);

        checkOutput("final_queue_empty", 16'(expQ.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
